// File: rtl/wb_regfile.sv
// Write-back register file: 32 x XLEN integer registers with a write-back
// source mux, same-cycle write-through bypass on both read ports, and a
// wrapping committed-write counter.
// Latency: reads are combinational (0 cycles); a write lands in storage
// one edge after it is presented and is visible through the bypass before then.
// Backpressure: none. A write-back is accepted every cycle and the block never stalls.
module wb_regfile #(
  parameter int XLEN = 64,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            regwrite,
  input  logic            memtoreg,
  input  logic [XLEN-1:0] alures,
  input  logic [XLEN-1:0] readmem,
  input  logic [4:0]      RD,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] wbdata,
  output logic            wbvalid,
  output logic [CNTW-1:0] wrcount
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  // Architectural state. Entry 0 is cleared by reset and never written,
  // so it stays zero, but the read mux still forces address 0 to zero.
  logic [XLEN-1:0] r_regs [32];
  logic [CNTW-1:0] r_wrcount;

  logic [XLEN-1:0] w_wbdata;
  logic            w_rd_nonzero;
  logic            w_wbvalid;
  logic            w_hit1;
  logic            w_hit2;
  logic [XLEN-1:0] w_rdata1;
  logic [XLEN-1:0] w_rdata2;

  // Select the write-back source. This is deliberately independent of reset
  // so that EX forwarding always sees the live MEM/WB value.
  always_comb begin
    w_wbdata = alures;
    if (memtoreg) begin
      w_wbdata = readmem;
    end
  end

  // A write commits only outside reset and only to a non-zero register.
  // When regwrite is low the AND gates away any unknown RD.
  always_comb begin
    w_rd_nonzero = (RD != 5'd0);
    w_wbvalid    = rst_n & regwrite & w_rd_nonzero;
  end

  // Bypass hit detection per port. The compare is qualified by w_wbvalid, so a
  // write to x0 or a write held off by reset never bypasses.
  always_comb begin
    w_hit1 = w_wbvalid && (RD == rs1);
    w_hit2 = w_wbvalid && (RD == rs2);
  end

  // Read port A: x0 reads zero, then the in-flight write wins, then storage.
  always_comb begin
    w_rdata1 = r_regs[rs1];
    if (rs1 == 5'd0) begin
      w_rdata1 = '0;
    end else if (w_hit1) begin
      w_rdata1 = w_wbdata;
    end
  end

  // Read port B: identical priority to port A, so both ports agree when they
  // name the register being written.
  always_comb begin
    w_rdata2 = r_regs[rs2];
    if (rs2 == 5'd0) begin
      w_rdata2 = '0;
    end else if (w_hit2) begin
      w_rdata2 = w_wbdata;
    end
  end

  // Register storage: synchronous clear on reset, otherwise commit the
  // selected write-back value into the destination register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wbvalid) begin
      r_regs[RD] <= w_wbdata;
    end
  end

  // Committed-write counter: wraps modulo 2^CNTW with no saturation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrcount <= '0;
    end else if (w_wbvalid) begin
      r_wrcount <= r_wrcount + CNT_ONE;
    end
  end

  assign rdata1  = w_rdata1;
  assign rdata2  = w_rdata2;
  assign wbdata  = w_wbdata;
  assign wbvalid = w_wbvalid;
  assign wrcount = r_wrcount;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back-stage register file for the 5-stage RISC-V core, receiving the MEM/WB pipeline register outputs. It selects the write-back value (ALU result or loaded data), commits it into 32 x 64-bit integer registers, and serves the two ID-stage read ports. Read ports bypass the same-cycle write-back, so ID never sees a stale value for a register being written that cycle. A committed-write counter supports sort-program bring-up and verification.

## Interface
- `XLEN`, 64: register and data width.
- `CNTW`, 32: width of the committed-write counter.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `regwrite`  in  1: write-back enable, from MEM/WB `regwriteout`.
- `memtoreg`  in  1: write-back source select, from MEM/WB `memtoregout`. 1 selects load data; 0 selects the ALU result.
- `alures`  in  XLEN: ALU result, from MEM/WB `aluresout`.
- `readmem`  in  XLEN: load data, from MEM/WB `readmemout`.
- `RD`  in  5: destination register, from MEM/WB `RDout`.
- `rs1`  in  5: ID read address A.
- `rs2`  in  5: ID read address B.
- `rdata1`  out  XLEN: value of `rs1`.
- `rdata2`  out  XLEN: value of `rs2`.
- `wbdata`  out  XLEN: selected write-back value, for EX forwarding.
- `wbvalid`  out  1: a register write commits this cycle.
- `wrcount`  out  CNTW: number of committed writes since reset.

## Operation
- **Write-back select** (combinational): `wbdata = memtoreg ? readmem : alures`.
- **Commit condition**: `wbvalid = rst_n & regwrite & (RD != 0)`.
- **Register write**: at each `clk` rising edge with `wbvalid` = 1, `regs[RD] <= wbdata`.
- **x0**: `regs[0]` is never written; reads of address 0 always return 0.
- **Read path** for each port p (combinational):
  - If `rs_p == 0`, the result is 0.
  - Else if `wbvalid` and `RD == rs_p`, the result is `wbdata` (write-through bypass).
  - Otherwise the result is `regs[rs_p]`.
- **Simultaneous reads**: both ports may name the same register, including the one being written. Both ports then return the identical bypassed value.
- **Write with `regwrite` = 1 and `RD` = 0**: no state changes, `wrcount` does not increment, and there is no bypass.
- **Committed-write counter**: `wrcount` increments by 1 on every edge where `wbvalid` = 1.
  - Unsigned, modulo 2^CNTW: all-ones wraps to 0.
  - No saturation and no overflow flag.
- **Reset** (`rst_n` = 0 at a rising edge):
  - All 32 registers are cleared to 0.
  - `wrcount` is cleared to 0.
  - Any concurrent write is discarded, because `wbvalid` is forced to 0 while `rst_n` = 0.
- **Reset mid-program**: asserting reset on any cycle, including one carrying a load write-back, leaves all registers at 0 on the next cycle.
- **X-propagation**: `memtoreg`, `alures`, `readmem` and `RD` are don't-care when `regwrite` = 0 and must not affect state.

## Timing
- **Write latency**: one edge. A value committed at edge N is readable from `regs` from cycle N+1.
- **Same-cycle visibility**: in the cycle before edge N, the value is already visible through the bypass.
- **Read latency**: zero cycles. Reads are combinational from `rs1`/`rs2` and the write-back inputs.
- **Reset values**:
  - `rdata1` = `rdata2` = 0 for any address.
  - `wrcount` = 0.
  - `wbvalid` = 0 while `rst_n` = 0.
  - `wbdata` follows its inputs and is unaffected by reset.
- **Reset release**: the first commit can occur on the first edge with `rst_n` = 1.
- **Timing path**: the critical path is `RD`/`rs` compare plus `memtoreg` mux into `rdata`, and it must close at the core clock. There are no internal pipeline registers on the read path.

## Test plan
- **Reset clears state**:
  - Stimulus: write `x5` = 0xDEAD_BEEF_0000_0001, then hold `rst_n` = 0 for 1 cycle with `regwrite` = 1, `RD` = 5, `alures` = 7.
  - Required: `rs1` = 5 reads 0 and `wrcount` = 0.
- **Source select and latency**:
  - Stimulus: `regwrite` = 1, `RD` = 10, `memtoreg` = 1, `readmem` = 0x1234, `alures` = 0x9999.
  - Required: `wbdata` = 0x1234 in the same cycle; after the edge, with `regwrite` = 0, `rs2` = 10 reads 0x1234; `wrcount` = 1.
- **Bypass**:
  - Stimulus: `x3` holds 0x11; in one cycle set `regwrite` = 1, `RD` = 3, `memtoreg` = 0, `alures` = 0x22, `rs1` = `rs2` = 3.
  - Required: `rdata1` = `rdata2` = 0x22 before the edge, and 0x22 after.
- **x0 protection**:
  - Stimulus: `regwrite` = 1, `RD` = 0, `alures` = 0xFFFF_FFFF_FFFF_FFFF, `rs1` = 0.
  - Required: `rdata1` = 0 before and after the edge; `wbvalid` = 0; `wrcount` unchanged.
- **Counter wrap**:
  - Stimulus: `CNTW` = 4; issue 17 commits to `x1`..`x17` (`RD` 1-17 cycling within 1-31).
  - Required: `wrcount` goes 15 then 0 at the 16th commit, and reads 1 after the 17th.
- **Don't-care inputs**:
  - Stimulus: `regwrite` = 0 with random `RD`, `alures`, `readmem` for 100 cycles.
  - Required: all registers and `wrcount` are unchanged, and `wbvalid` stays 0.
